// File: rtl/chip8_pkg.sv
// rtl/chip8_pkg.sv - shared CHIP-8 memory constants, arbiter states and requester indices.
package chip8_pkg;

   localparam int MEM_AW = 12;
   localparam int MEM_DW = 8;

   localparam int REQ_CPU  = 0;
   localparam int REQ_DRAW = 1;
   localparam int REQ_LOAD = 2;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } arb_state_t;

endpackage

// File: rtl/chip8_prio_pick.sv
// rtl/chip8_prio_pick.sv - combinational picker: first set req bit at or after start, wrapping.
module chip8_prio_pick #(
   parameter int N  = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic [IW-1:0] grant,
   output logic          valid
);

   logic [IW:0] pos;

   always_comb begin
      grant = '0;
      valid = 1'b0;
      pos   = '0;
      for (int i = 0; i < N; i++) begin
         pos = {1'b0, start} + (IW+1)'(i);
         if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
         if (!valid && req[pos[IW-1:0]]) begin
            valid = 1'b1;
            grant = pos[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/chip8_mem_arbiter.sv
// rtl/chip8_mem_arbiter.sv - single-port CHIP-8 memory arbiter with locked sequences.
// Define ARB_ROUND_ROBIN_EN for rotating non-locked grants; default build is fixed priority.
module chip8_mem_arbiter
   import chip8_pkg::*;
#(
   parameter int N_REQ    = 3,
   parameter int AW       = MEM_AW,
   parameter int DW       = MEM_DW,
   parameter int READ_LAT = 1,
   localparam int OW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ-1:0]    lock,
   input  logic [N_REQ-1:0]    we,
   input  logic [N_REQ*AW-1:0] addr,
   input  logic [N_REQ*DW-1:0] wdata,
   output logic [N_REQ-1:0]    ack,
   output logic [DW-1:0]       rdata,
   output logic [OW-1:0]       owner,
   output logic                busy,
   output logic                mem_en,
   output logic                mem_we,
   output logic [AW-1:0]       mem_addr,
   output logic [DW-1:0]       mem_wdata,
   input  logic [DW-1:0]       mem_rdata
);

   localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);

   arb_state_t    state_q, state_d;
   logic [OW-1:0] owner_q, hold_idx_q, pick_idx, grant_idx, start;
   logic          hold_q, pick_valid, grant_en, we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q, rdata_q;
   logic [1:0]    cnt_q;

`ifdef ARB_ROUND_ROBIN_EN
   logic [OW-1:0] last_q;

   // Reset value N_REQ-1 makes the first rotating search start at requester 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        last_q <= OW'(N_REQ - 1);
      else if (grant_en) last_q <= grant_idx;
   end

   assign start = (last_q == OW'(N_REQ - 1)) ? '0 : last_q + 1'b1;
`else
   assign start = '0;
`endif

   chip8_prio_pick #(.N(N_REQ), .IW(OW)) u_pick (
      .req   (req),
      .start (start),
      .grant (pick_idx),
      .valid (pick_valid)
   );

   always_comb begin
      state_d   = state_q;
      grant_en  = 1'b0;
      grant_idx = pick_idx;
      case (state_q)
         IDLE: begin
            // A lock holder blocks everyone else even while its own req is low.
            if (hold_q) begin
               if (req[hold_idx_q]) begin
                  grant_en  = 1'b1;
                  grant_idx = hold_idx_q;
               end
            end else if (pick_valid) begin
               grant_en = 1'b1;
            end
            if (grant_en) state_d = ISSUE;
         end
         ISSUE: state_d = (we_q || READ_LAT <= 1) ? DONE : WAIT;
         WAIT:  if (cnt_q <= 2'd1) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         cnt_q      <= '0;
         hold_q     <= 1'b0;
         hold_idx_q <= '0;
      end else begin
         state_q <= state_d;
         if (grant_en) begin
            owner_q <= grant_idx;
            we_q    <= we[grant_idx];
            addr_q  <= addr[int'(grant_idx)*AW +: AW];
            wdata_q <= wdata[int'(grant_idx)*DW +: DW];
         end
         if (state_q == ISSUE)     cnt_q <= LAT_M1;
         else if (state_q == WAIT) cnt_q <= cnt_q - 2'd1;
         if (state_q == DONE) begin
            if (!we_q) rdata_q <= mem_rdata;
            hold_q     <= lock[owner_q];
            hold_idx_q <= owner_q;
         end
      end
   end

   always_comb begin
      ack = '0;
      if (state_q == DONE) ack[owner_q] = 1'b1;
   end

   // Read data is forwarded straight from memory in the ack cycle, then held.
   assign rdata     = (state_q == DONE && !we_q) ? mem_rdata : rdata_q;
   assign owner     = owner_q;
   assign busy      = (state_q != IDLE);
   assign mem_en    = (state_q == ISSUE);
   assign mem_we    = mem_en & we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// tb/tb_chip8_mem_arbiter.sv - scoreboard bench: READ_LAT=1 and READ_LAT=3 arbiter instances.
module tb_chip8_mem_arbiter;

   typedef struct {
      int         idx;
      bit         rd;
      logic [7:0] d;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0, rst3_n = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]  req0, lock0, we0, ack0, req3, lock3, we3, ack3;
   logic [35:0] addr0, addr3;
   logic [23:0] wdata0, wdata3;
   logic [7:0]  rdata0, rdata3, mwd0, mwd3, mrd0, mrd3, p1, p2;
   logic [1:0]  owner0, owner3;
   logic        busy0, busy3, men0, men3, mwe0, mwe3;
   logic [11:0] maddr0, maddr3;
   logic [7:0]  mem0 [4096];
   logic [7:0]  mem3 [4096];

   exp_t q0[$];
   exp_t q3[$];
   int   n_cmp = 0, n_bad = 0;

   chip8_mem_arbiter #(.N_REQ(3), .AW(12), .DW(8), .READ_LAT(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .req(req0), .lock(lock0), .we(we0), .addr(addr0),
      .wdata(wdata0), .ack(ack0), .rdata(rdata0), .owner(owner0), .busy(busy0),
      .mem_en(men0), .mem_we(mwe0), .mem_addr(maddr0), .mem_wdata(mwd0), .mem_rdata(mrd0)
   );

   chip8_mem_arbiter #(.N_REQ(3), .AW(12), .DW(8), .READ_LAT(3)) u_dut3 (
      .clk(clk), .rst_n(rst3_n), .req(req3), .lock(lock3), .we(we3), .addr(addr3),
      .wdata(wdata3), .ack(ack3), .rdata(rdata3), .owner(owner3), .busy(busy3),
      .mem_en(men3), .mem_we(mwe3), .mem_addr(maddr3), .mem_wdata(mwd3), .mem_rdata(mrd3)
   );

   // Memory models: contents set once, then serviced every rising edge.
   initial begin
      for (int i = 0; i < 4096; i++) begin
         mem0[i] = 8'(i * 7 + 3);
         mem3[i] = 8'(i * 7 + 3);
      end
      mem0[12'h200] = 8'h12;
      mem0[12'h201] = 8'h34;
      mem0[12'h010] = 8'h3C;
      mem0[12'h020] = 8'h5A;
      mem3[12'h0FF] = 8'h77;
      mem3[12'h020] = 8'h5A;
      mrd0 = 8'hEE;
      p1 = 8'hEE;
      p2 = 8'hEE;
      mrd3 = 8'hEE;
      forever begin
         @(posedge clk);
         if (men0 && mwe0) mem0[maddr0] = mwd0;
         mrd0 <= (men0 && !mwe0) ? mem0[maddr0] : 8'hEE;
         p1   <= men3 ? mem3[maddr3] : 8'hEE;
         p2   <= p1;
         mrd3 <= p2;
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         for (int i = 0; i < 3; i++) begin
            if (ack0[i]) begin
               if (q0.size() == 0) begin
                  chk("unexpected_ack0", i, 32'hFFFF);
               end else begin
                  e = q0.pop_front();
                  chk("ack0_idx", i, e.idx);
                  if (e.rd) chk("ack0_rdata", rdata0, e.d);
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst3_n) begin
         for (int i = 0; i < 3; i++) begin
            if (ack3[i]) begin
               if (q3.size() == 0) begin
                  chk("unexpected_ack3", i, 32'hFFFF);
               end else begin
                  e = q3.pop_front();
                  chk("ack3_idx", i, e.idx);
                  if (e.rd) chk("ack3_rdata", rdata3, e.d);
               end
            end
         end
      end
   end

   task automatic drive0(int i, bit w, logic [11:0] a, logic [7:0] d, bit lk);
      we0[i] = w;
      lock0[i] = lk;
      addr0[i*12 +: 12] = a;
      wdata0[i*8 +: 8] = d;
      req0[i] = 1'b1;
   endtask

   task automatic drive3(int i, logic [11:0] a);
      we3[i] = 1'b0;
      lock3[i] = 1'b0;
      addr3[i*12 +: 12] = a;
      req3[i] = 1'b1;
   endtask

   task automatic wait_ack0(int i, bit drop, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!ack0[i] && cyc < 40);
      if (!ack0[i]) chk("timeout_ack0", 0, 1);
      else if (drop) req0[i] = 1'b0;
   endtask

   task automatic wait_ack3(int i, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!ack3[i] && cyc < 40);
      if (!ack3[i]) chk("timeout_ack3", 0, 1);
      else req3[i] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c1, c2;
      req0 = '0; lock0 = '0; we0 = '0; addr0 = '0; wdata0 = '0;
      req3 = '0; lock3 = '0; we3 = '0; addr3 = '0; wdata3 = '0;
      repeat (3) @(negedge clk);
      chk("rst_ack", ack0, 0);
      chk("rst_mem_en", men0, 0);
      chk("rst_mem_we", mwe0, 0);
      chk("rst_mem_addr", maddr0, 0);
      chk("rst_mem_wdata", mwd0, 0);
      chk("rst_rdata", rdata0, 0);
      chk("rst_owner", owner0, 0);
      chk("rst_busy", busy0, 0);
      rst_n = 1'b1;
      rst3_n = 1'b1;
      @(negedge clk);

      // Contention straight after reset: both builds serve requester 0 first.
      q0.push_back('{0, 1'b1, 8'h3C});
      q0.push_back('{1, 1'b1, 8'h5A});
      drive0(0, 1'b0, 12'h010, 8'h00, 1'b0);
      drive0(1, 1'b0, 12'h020, 8'h00, 1'b0);
      fork
         wait_ack0(0, 1'b1, c1);
         wait_ack0(1, 1'b1, c2);
      join
      chk("contA_lat0", c1, 2);
      chk("contA_lat1", c2, 5);

      // Single CPU read with cycle-exact timing.
      @(negedge clk);
      q0.push_back('{0, 1'b1, 8'h12});
      drive0(0, 1'b0, 12'h200, 8'h00, 1'b0);
      @(negedge clk);
      chk("rd_mem_en", men0, 1);
      chk("rd_mem_addr", maddr0, 12'h200);
      chk("rd_mem_we", mwe0, 0);
      chk("rd_busy", busy0, 1);
      chk("rd_no_early_ack", ack0, 0);
      @(negedge clk);
      chk("rd_ack_t2", ack0, 3'b001);
      req0[0] = 1'b0;
      @(negedge clk);
      chk("rdata_hold", rdata0, 8'h12);
      chk("idle_busy", busy0, 0);
      chk("idle_mem_en", men0, 0);

      // Repeat contention: rotation now favours requester 1.
`ifdef ARB_ROUND_ROBIN_EN
      q0.push_back('{1, 1'b1, 8'h5A});
      q0.push_back('{0, 1'b1, 8'h3C});
`else
      q0.push_back('{0, 1'b1, 8'h3C});
      q0.push_back('{1, 1'b1, 8'h5A});
`endif
      drive0(0, 1'b0, 12'h010, 8'h00, 1'b0);
      drive0(1, 1'b0, 12'h020, 8'h00, 1'b0);
      fork
         wait_ack0(0, 1'b1, c1);
         wait_ack0(1, 1'b1, c2);
      join
`ifdef ARB_ROUND_ROBIN_EN
      chk("contB_lat0", c1, 5);
      chk("contB_lat1", c2, 2);
`else
      chk("contB_lat0", c1, 2);
      chk("contB_lat1", c2, 5);
`endif

      // Loader writes 0xA5 to 0x300 then reads it back.
      @(negedge clk);
      q0.push_back('{2, 1'b0, 8'h00});
      drive0(2, 1'b1, 12'h300, 8'hA5, 1'b0);
      @(negedge clk);
      chk("wr_mem_en", men0, 1);
      chk("wr_mem_we", mwe0, 1);
      chk("wr_mem_addr", maddr0, 12'h300);
      chk("wr_mem_wdata", mwd0, 8'hA5);
      @(negedge clk);
      chk("wr_ack_t2", ack0, 3'b100);
      chk("wr_we_done", mwe0, 0);
      req0[2] = 1'b0;
      @(negedge clk);
      q0.push_back('{2, 1'b1, 8'hA5});
      drive0(2, 1'b0, 12'h300, 8'h00, 1'b0);
      @(negedge clk);
      chk("rb_mem_en", men0, 1);
      chk("rb_mem_we", mwe0, 0);
      wait_ack0(2, 1'b1, c1);
      chk("rb_lat", c1, 1);

      // Locked two-byte fetch while the draw engine keeps requesting.
      @(negedge clk);
      q0.push_back('{0, 1'b1, 8'h12});
      q0.push_back('{0, 1'b1, 8'h34});
      q0.push_back('{1, 1'b1, 8'h5A});
      drive0(0, 1'b0, 12'h200, 8'h00, 1'b1);
      @(negedge clk);
      drive0(1, 1'b0, 12'h020, 8'h00, 1'b0);
      wait_ack0(0, 1'b0, c1);
      chk("lock_first_lat", c1, 1);
      @(negedge clk);
      addr0[11:0] = 12'h201;
      lock0[0] = 1'b0;
      wait_ack0(0, 1'b1, c1);
      chk("lock_second_lat", c1, 2);
      wait_ack0(1, 1'b1, c2);
      chk("lock_release_lat", c2, 3);
      chk("lock_owner", owner0, 1);

      // READ_LAT=3 instance: ack at t+4, busy t+1..t+4.
      @(negedge clk);
      q3.push_back('{0, 1'b1, 8'h77});
      drive3(0, 12'h0FF);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("lat3_busy", busy3, 1);
         chk("lat3_ack", ack3[0], (k == 4) ? 1 : 0);
         chk("lat3_mem_en", men3, (k == 1) ? 1 : 0);
         if (k == 1) chk("lat3_mem_addr", maddr3, 12'h0FF);
      end
      req3[0] = 1'b0;
      @(negedge clk);
      chk("lat3_busy_after", busy3, 0);

      // Reset while the read sits in WAIT: everything drops, no ack.
      drive3(2, 12'h020);
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_busy", busy3, 1);
      #2 rst3_n = 1'b0;
      #1;
      chk("arst_ack", ack3, 0);
      chk("arst_mem_en", men3, 0);
      chk("arst_mem_we", mwe3, 0);
      chk("arst_mem_addr", maddr3, 0);
      chk("arst_mem_wdata", mwd3, 0);
      chk("arst_rdata", rdata3, 0);
      chk("arst_owner", owner3, 0);
      chk("arst_busy", busy3, 0);
      req3[2] = 1'b0;
      repeat (3) @(negedge clk);
      chk("arst_hold_ack", ack3, 0);
      rst3_n = 1'b1;
      @(negedge clk);
      q3.push_back('{1, 1'b1, 8'h5A});
      drive3(1, 12'h020);
      wait_ack3(1, c1);
      chk("post_rst_lat", c1, 4);

      repeat (4) @(negedge clk);
      chk("q0_drained", q0.size(), 0);
      chk("q3_drained", q3.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
